// File: rtl/score_packer_pkg.sv
// Shared constants, state encoding and slot mapping for the score packer.
package score_packer_pkg;

  localparam int N_CLASS = 10;

  // Reference score width used for the shared sign-magnitude codes.
  localparam int SM_BIT = 16;

  // Saturated-maximum marker (ranked highest by argmax) and most negative code.
  localparam logic [SM_BIT-1:0] SM_MARKER  = {1'b1, {(SM_BIT-1){1'b0}}};
  localparam logic [SM_BIT-1:0] SM_NEG_MAX = {SM_BIT{1'b1}};

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Digit d lives in slot 9-d of the packed argmax vector.
  function automatic int slot_of(input int digit);
    return N_CLASS - 1 - digit;
  endfunction

endpackage

// File: rtl/sm_saturate.sv
// Rescales a two's complement accumulator and converts it to saturating
// sign-magnitude. Overflow high maps to the marker code, overflow low to the
// most negative code; both raise the sat flag.
module sm_saturate #(
  parameter int BIT        = 16,
  parameter int ACC_W      = 32,
  parameter int FRAC_SHIFT = 8
) (
  input  logic [ACC_W-1:0] acc,
  output logic [BIT-1:0]   sm,
  output logic             sat
);

  localparam int MW = BIT - 1;
  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((longint'(1) << (BIT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;
  localparam logic [BIT-1:0] MARKER  = {1'b1, {(BIT-1){1'b0}}};
  localparam logic [BIT-1:0] NEG_MAX = {BIT{1'b1}};

  logic signed [ACC_W-1:0] s;

  // Floor-rescale, then clamp into the symmetric sign-magnitude range.
  always_comb begin
    s   = $signed(acc) >>> FRAC_SHIFT;
    sm  = '0;
    sat = 1'b0;
    if (s > POS_LIM) begin
      sm  = MARKER;
      sat = 1'b1;
    end else if (s < NEG_LIM) begin
      sm  = NEG_MAX;
      sat = 1'b1;
    end else if (s < 0) begin
      sm = {1'b1, MW'(-s)};
    end else begin
      sm = {1'b0, MW'(s)};
    end
  end

endmodule

// File: rtl/score_packer.sv
// Collects ten serial accumulator results, converts each to sign-magnitude
// and presents them as one packed vector to the argmax stage.
module score_packer
  import score_packer_pkg::*;
#(
  parameter int BIT        = 16,
  parameter int ACC_W      = 32,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACC_W-1:0]       acc_in,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic                   frame_clr,
  output logic [N_CLASS*BIT-1:0] vec_out,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic [3:0]             sat_cnt
);

  state_t         state;
  state_t         state_next;
  logic [3:0]     k;
  logic [BIT-1:0] score;
  logic           score_sat;
  logic           take;
  logic           last;

  sm_saturate #(
    .BIT        (BIT),
    .ACC_W      (ACC_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_sat (
    .acc (acc_in),
    .sm  (score),
    .sat (score_sat)
  );

  // A sample is taken only in COLLECT, and a frame abort swallows it.
  always_comb begin
    take = (state == COLLECT) && acc_valid && !frame_clr;
    last = (k == 4'(N_CLASS - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // Next state and handshake outputs; ready is held low while in reset.
  always_comb begin
    state_next = state;
    acc_ready  = 1'b0;
    vec_valid  = 1'b0;
    case (state)
      COLLECT: begin
        acc_ready = !rst;
        if (take && last) state_next = HOLD;
      end
      HOLD: begin
        vec_valid = 1'b1;
        if (vec_ready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Slot writes, digit counter and saturation count; frozen while holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      vec_out <= '0;
      sat_cnt <= '0;
    end else if (state == COLLECT) begin
      if (frame_clr) begin
        k       <= '0;
        vec_out <= '0;
        sat_cnt <= '0;
      end else if (take) begin
        for (int i = 0; i < N_CLASS; i++) begin
          if (i == slot_of(int'(k))) vec_out[i*BIT +: BIT] <= score;
        end
        k       <= last ? 4'd0 : k + 4'd1;
        sat_cnt <= sat_cnt + 4'(score_sat);
      end
    end else if (vec_ready) begin
      sat_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_score_packer.sv
// Self-checking bench for score_packer: directed scenarios plus random
// traffic, compared every cycle against a frame-level behavioural model.
module tb_score_packer;
  import score_packer_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  acc_in = '0;
  logic         acc_valid = 1'b0;
  logic         acc_ready;
  logic         frame_clr = 1'b0;
  logic [159:0] vec_out;
  logic         vec_valid;
  logic         vec_ready = 1'b0;
  logic [3:0]   sat_cnt;

  int checks = 0;
  int passes = 0;

  // Model state: scores indexed by digit, not by slot.
  logic [15:0] m_score [10];
  int          m_k = 0;
  bit          m_hold = 1'b0;
  int          m_sat = 0;

  score_packer dut (
    .clk       (clk),
    .rst       (rst),
    .acc_in    (acc_in),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .frame_clr (frame_clr),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  // Floor division by 256 done with integer arithmetic, then clamped.
  function automatic logic [15:0] conv(input logic [31:0] a, output bit satf);
    longint v = longint'($signed(a));
    longint r = ((v % 256) + 256) % 256;
    longint s = (v - r) / 256;
    satf = 1'b0;
    if (s > 32767) begin satf = 1'b1; return SM_MARKER; end
    if (s < -32767) begin satf = 1'b1; return SM_NEG_MAX; end
    if (s < 0) return {1'b1, 15'(-s)};
    return {1'b0, 15'(s)};
  endfunction

  function automatic logic [159:0] packed_model();
    logic [159:0] v = '0;
    for (int d = 0; d < 10; d++) v[(9-d)*16 +: 16] = m_score[d];
    return v;
  endfunction

  // Argmax over sign-magnitude scores; marker ranks highest, lowest digit wins ties.
  function automatic int argmax(input logic [159:0] v);
    int best = 0;
    longint best_rank = 0;
    for (int d = 0; d < 10; d++) begin
      logic [15:0] c = v[(9-d)*16 +: 16];
      longint rank;
      if (c == SM_MARKER) rank = 100000;
      else if (c[15])     rank = -longint'(c[14:0]);
      else                rank = longint'(c[14:0]);
      if (d == 0 || rank > best_rank) begin best = d; best_rank = rank; end
    end
    return best;
  endfunction

  function automatic logic [31:0] rand_acc(input bit in_range);
    logic [31:0] bnd [6];
    int sel = in_range ? $urandom_range(0, 1) : $urandom_range(0, 3);
    bnd[0] = 32'h007FFF00; bnd[1] = 32'h007FFFFF; bnd[2] = 32'h00800000;
    bnd[3] = 32'hFF800100; bnd[4] = 32'hFF8000FF; bnd[5] = 32'hFF800000;
    case (sel)
      0:       return 32'($urandom_range(0, 32767 * 256));
      1:       return -32'($urandom_range(0, 32767 * 256));
      2:       return $urandom;
      default: return bnd[$urandom_range(0, 5)];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] actual,
                             input logic [159:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drive one cycle of inputs and return just after the active edge.
  task automatic applyStimulus(input bit v, input logic [31:0] a,
                               input bit clr, input bit rdy);
    acc_valid = v;
    acc_in    = a;
    frame_clr = clr;
    vec_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: frame collection, abort, hold and release.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 10; d++) m_score[d] <= '0;
      m_k    <= 0;
      m_hold <= 1'b0;
      m_sat  <= 0;
    end else if (!m_hold) begin
      if (frame_clr) begin
        for (int d = 0; d < 10; d++) m_score[d] <= '0;
        m_k   <= 0;
        m_sat <= 0;
      end else if (acc_valid) begin
        bit sf;
        m_score[m_k] <= conv(acc_in, sf);
        m_sat        <= m_sat + int'(sf);
        m_k          <= (m_k == 9) ? 0 : m_k + 1;
        if (m_k == 9) m_hold <= 1'b1;
      end
    end else if (vec_ready) begin
      m_hold <= 1'b0;
      m_sat  <= 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("vec_valid", 160'(vec_valid), 160'(m_hold));
    checkOutput("acc_ready", 160'(acc_ready), 160'(!m_hold && !rst));
    checkOutput("sat_cnt", 160'(sat_cnt), 160'(m_sat));
    checkOutput("vec_out", vec_out, packed_model());
  end

  initial begin
    logic [159:0] held;
    logic [31:0]  codes [5];
    codes[0] = 32'hFFFFFB00; codes[1] = 32'hFFFFFFFF; codes[2] = 32'h00800000;
    codes[3] = 32'h80000000; codes[4] = 32'h00000000;

    #2;
    checkOutput("reset_vec_out", vec_out, '0);
    checkOutput("reset_vec_valid", 160'(vec_valid), 160'(0));
    checkOutput("reset_acc_ready", 160'(acc_ready), 160'(0));
    checkOutput("reset_sat_cnt", 160'(sat_cnt), 160'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Ascending frame with valid held high.
    for (int d = 0; d < 10; d++) begin
      if (d == 9) checkOutput("no_early_valid", 160'(vec_valid), 160'(0));
      applyStimulus(1'b1, 32'((d + 1) << 8), 1'b0, 1'b0);
    end
    checkOutput("latency_valid", 160'(vec_valid), 160'(1));
    checkOutput("digit0_slot", 160'(vec_out[159:144]), 160'(16'h0001));
    checkOutput("digit9_slot", 160'(vec_out[15:0]), 160'(16'h000A));
    checkOutput("asc_sat_cnt", 160'(sat_cnt), 160'(0));
    held = vec_out;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0);
      checkOutput("hold_ready_low", 160'(acc_ready), 160'(0));
      checkOutput("hold_stable", vec_out, held);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("release_valid", 160'(vec_valid), 160'(0));
    checkOutput("release_ready", 160'(acc_ready), 160'(1));

    // Sign and saturation codes.
    for (int d = 0; d < 10; d++)
      applyStimulus(1'b1, d < 5 ? codes[d] : 32'(d << 8), 1'b0, 1'b0);
    checkOutput("code_neg5", 160'(vec_out[159:144]), 160'(16'h8005));
    checkOutput("code_neg1", 160'(vec_out[143:128]), 160'(16'h8001));
    checkOutput("code_marker", 160'(vec_out[127:112]), 160'(16'h8000));
    checkOutput("code_negmax", 160'(vec_out[111:96]), 160'(16'hFFFF));
    checkOutput("code_zero", 160'(vec_out[95:80]), 160'(16'h0000));
    checkOutput("code_sat_cnt", 160'(sat_cnt), 160'(2));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Abort after four samples; the aborting sample is dropped.
    for (int d = 0; d < 4; d++) applyStimulus(1'b1, 32'((d + 5) << 8), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00009900, 1'b1, 1'b0);
    for (int d = 0; d < 10; d++) applyStimulus(1'b1, 32'((d + 17) << 8), 1'b0, 1'b0);
    checkOutput("clr_valid", 160'(vec_valid), 160'(1));
    checkOutput("clr_first_slot", 160'(vec_out[159:144]), 160'(16'h0011));
    checkOutput("clr_last_slot", 160'(vec_out[15:0]), 160'(16'h001A));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame at k=6.
    for (int d = 0; d < 6; d++) applyStimulus(1'b1, 32'h00800000, 1'b0, 1'b0);
    acc_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_vec", vec_out, '0);
    checkOutput("rst_mid_sat", 160'(sat_cnt), 160'(0));
    checkOutput("rst_mid_ready", 160'(acc_ready), 160'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 10; d++) applyStimulus(1'b1, 32'((d + 1) << 8), 1'b0, 1'b0);
    checkOutput("post_rst_digit0", 160'(vec_out[159:144]), 160'(16'h0001));
    checkOutput("post_rst_valid", 160'(vec_valid), 160'(1));

    // Asynchronous reset while holding.
    acc_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_hold_valid", 160'(vec_valid), 160'(0));
    checkOutput("rst_hold_vec", vec_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Argmax frame with a marker at digit 3.
    for (int d = 0; d < 10; d++)
      applyStimulus(1'b1, d == 3 ? 32'h00800000 : rand_acc(1'b1), 1'b0, 1'b0);
    checkOutput("argmax_marker_slot6", 160'(vec_out[111:96]), 160'(16'h8000));
    checkOutput("argmax_digit", 160'(argmax(vec_out)), 160'(3));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 3) != 0, rand_acc(1'b0),
                    $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);

    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/score_packer.md
Name: score_packer

Overview:
- Front end feeding the 10-way argmax comparator. It collects the 10 output-layer accumulator results serially over a valid/ready stream.
- Each result is converted from wide two's complement to BIT-wide sign-magnitude, with saturation.
- The 10 converted scores are packed into one 10*BIT vector and held until the argmax stage accepts it.
- Slot order and encodings match the argmax input: digit d occupies slot 9-d, and code {1,0..0} is the "saturated maximum" marker.

Parameters:
- BIT, 16, width of one sign-magnitude score (MSB = sign).
- ACC_W, 32, width of the two's complement accumulator input.
- FRAC_SHIFT, 8, arithmetic right shift applied before conversion (fixed-point rescale).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- acc_in  in  ACC_W  accumulator result; the digit index is implied by arrival order (first = digit 0).
- acc_valid  in  1  acc_in valid.
- acc_ready  out  1  packer can accept acc_in.
- frame_clr  in  1  synchronous abort of the partial frame.
- vec_out  out  10*BIT  packed scores; digit d at bits [(9-d)*BIT+BIT-1 -: BIT].
- vec_valid  out  1  vec_out holds a complete frame.
- vec_ready  in  1  downstream accepts vec_out.
- sat_cnt  out  4  number of saturated scores (either sign) in the presented frame.

Behaviour:
- Reset (asynchronous, rst=1): state=COLLECT, digit counter k=0, vec_out=0, vec_valid=0, acc_ready=0 while rst is high, sat_cnt=0.
- COLLECT state:
  - acc_ready=1. A handshake occurs when acc_valid&acc_ready.
  - On a handshake, the converted score is written to slot 9-k, k increments, and sat_cnt accumulates.
  - On the handshake with k=9: next state is HOLD, vec_valid=1 on the following edge (latency 1 cycle after the 10th handshake), k returns to 0.
- HOLD state:
  - acc_ready=0. vec_out and sat_cnt stay stable.
  - On vec_valid&vec_ready: vec_valid=0, state=COLLECT, sat_cnt=0.
  - There is no same-cycle bypass: acc_ready rises the cycle after acceptance.
- frame_clr:
  - In COLLECT: k=0, sat_cnt=0, vec_out slots zeroed. A handshake in the same cycle is discarded.
  - In HOLD: ignored, because a completed frame is never dropped.
- Stale data: slots not yet written in the current frame keep their previous value. Only vec_valid qualifies vec_out.
- Conversion, all combinational, performed in the sub-module:
  - s = acc_in >>> FRAC_SHIFT (sign-extending).
  - s > 2^(BIT-1)-1 gives {1,0..0} (the marker, which argmax ranks highest); counts as saturated.
  - s < -(2^(BIT-1)-1) gives {1,1..1} (most negative); counts as saturated.
  - s < 0 gives {1, |s|[BIT-2:0]}.
  - s >= 0 gives {0, s[BIT-2:0]}.
  - Negative zero is never produced. Flooring means -1 >>> FRAC_SHIFT yields {1,0..01}.
- Simultaneous events:
  - rst dominates everything.
  - frame_clr dominates a COLLECT handshake.
  - acc_valid is ignored in HOLD; the upstream must hold its data.
- Width rules:
  - The comparison uses ACC_W-bit signed arithmetic.
  - The saturation threshold constants are sized to ACC_W.
  - sat_cnt saturates naturally at 10 (it fits in 4 bits).

Decomposition:
- Shared package:
  - N_CLASS=10.
  - SM_MARKER = {1'b1,{(BIT-1){1'b0}}}.
  - SM_NEG_MAX = {BIT{1'b1}}.
  - FSM state encoding COLLECT=1'b0, HOLD=1'b1.
- One sub-module, sm_saturate (combinational, parameters BIT/ACC_W/FRAC_SHIFT): input is acc; outputs are sm score and sat flag.

Test Plan (BIT=16, ACC_W=32, FRAC_SHIFT=8):
- Digits 0..9 get acc=(d+1)<<8 with acc_valid held high -> 10 handshakes. vec_valid rises 1 cycle after the 10th. Bits[159:144]=0x0001, bits[15:0]=0x000A, sat_cnt=0.
- Sign and saturation codes:
  - acc=0xFFFFFB00 -> slot 0x8005.
  - acc=0xFFFFFFFF -> 0x8001.
  - acc=0x00800000 -> 0x8000, sat_cnt increments.
  - acc=0x80000000 -> 0xFFFF, sat_cnt increments.
  - acc=0 -> 0x0000.
- Hold with vec_ready=0 for 5 cycles:
  - acc_ready=0 and vec_out unchanged throughout.
  - Raise vec_ready -> vec_valid falls next edge; acc_ready=1 the cycle after.
- frame_clr after 4 handshakes (with acc_valid high that cycle) -> that sample is dropped. The next 10 samples form the frame, starting at slot 9.
- Assert rst asynchronously mid-frame (k=6) and mid-HOLD -> outputs are zero immediately. The next frame starts at digit 0.
- Feed a frame into the argmax model with digit 3 = 0x00800000 -> marker in slot 6, argmax reports digit 3.
